// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : Word-addressed 32-bit data memory with a clocked write port,
//                a combinational read port and asynchronous reset to INIT_VALUE.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
    // One bit wider than the word index so the full 2^30-word range still compares correctly
    localparam logic [30:0] c_DEPTH = 31'(DEPTH_WORDS);

    logic [29:0]        w_word;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_unused_byte_offset;
    logic [31:0]        r_mem [DEPTH_WORDS];

    assign w_word               = addr[31:2];
    assign w_in_range           = ({1'b0, w_word} < c_DEPTH);
    assign w_idx                = w_word[c_IDX_W-1:0];
    assign w_unused_byte_offset = ^addr[1:0];

    // Each word is its own register so reset clears the whole array without a clock
    for (genvar i = 0; i < int'(DEPTH_WORDS); i++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[i] <= INIT_VALUE;
            end else if (MemWrite && w_in_range && (w_idx == c_IDX_W'(i))) begin
                r_mem[i] <= write_data;
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (MemRead && w_in_range) begin
            read_data = r_mem[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem
//  Description : Self-checking bench for data_mem against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

    localparam int unsigned DEPTH      = 16;
    localparam logic [31:0] INIT_VALUE = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int          n_checks;
    int          n_fail;
    logic [31:0] model [DEPTH];
    logic [31:0] exp;

    data_mem #(
        .DEPTH_WORDS (DEPTH),
        .INIT_VALUE  (INIT_VALUE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
        longint unsigned w;
        w = longint'(a) / 4;
        if (rd && w < DEPTH) return model[w];
        return 32'h0;
    endfunction

    // Applied after a rising edge: what the memory should now hold
    task automatic model_edge();
        longint unsigned w;
        w = longint'(addr) / 4;
        if (rst_n && MemWrite && w < DEPTH) model[w] = write_data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = INIT_VALUE;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; write_data = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b1; addr = 32'd4; write_data = 32'h0;
        model_reset();
        #1;
        n_checks++;
        if (read_data !== INIT_VALUE) begin
            n_fail++;
            $display("FAIL reset_read: got %h expected %h", read_data, INIT_VALUE);
        end
        MemRead = 1'b0;
        #1;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_gated: got %h expected %h", read_data, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(32'd4, 32'h1234ABCD);
        addr = 32'd4; MemRead = 1'b1;
        #1;
        n_checks++;
        if (read_data !== 32'h1234ABCD) begin
            n_fail++;
            $display("FAIL write_read: got %h expected %h", read_data, 32'h1234ABCD);
        end
    endtask

    task automatic test_second_word();
        do_write(32'd8, 32'hBEEFBEEF);
        addr = 32'd8; MemRead = 1'b1;
        #1;
        n_checks++;
        if (read_data !== 32'hBEEFBEEF) begin
            n_fail++;
            $display("FAIL second_word: got %h expected %h", read_data, 32'hBEEFBEEF);
        end
        addr = 32'd4;
        #1;
        n_checks++;
        if (read_data !== 32'h1234ABCD) begin
            n_fail++;
            $display("FAIL first_word_kept: got %h expected %h", read_data, 32'h1234ABCD);
        end
    endtask

    task automatic test_read_gating();
        addr = 32'd4; MemRead = 1'b0;
        #1;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL read_gated: got %h expected %h", read_data, 32'h0);
        end
        MemRead = 1'b1;
        for (int a = 5; a <= 7; a++) begin
            addr = 32'(a);
            #1;
            n_checks++;
            if (read_data !== 32'h1234ABCD) begin
                n_fail++;
                $display("FAIL misaligned addr=%0d: got %h expected %h", a, read_data, 32'h1234ABCD);
            end
        end
    endtask

    task automatic test_out_of_range();
        do_write(32'(4 * DEPTH), 32'hFFFFFFFF);
        addr = 32'(4 * DEPTH); MemRead = 1'b1;
        #1;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got %h expected %h", read_data, 32'h0);
        end
        addr = 32'd0;
        #1;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_no_alias: got %h expected %h", read_data, 32'h0);
        end
    endtask

    task automatic test_same_word();
        @(negedge clk);
        addr = 32'd8; MemRead = 1'b1; MemWrite = 1'b1; write_data = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (read_data !== 32'hBEEFBEEF) begin
            n_fail++;
            $display("FAIL same_word_before: got %h expected %h", read_data, 32'hBEEFBEEF);
        end
        @(posedge clk);
        model_edge();
        #1;
        n_checks++;
        if (read_data !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL same_word_after: got %h expected %h", read_data, 32'hCAFEF00D);
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        MemRead = 1'b1; addr = 32'd4;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (read_data !== INIT_VALUE) begin
            n_fail++;
            $display("FAIL async_reset_w1: got %h expected %h", read_data, INIT_VALUE);
        end
        addr = 32'd8;
        #1;
        n_checks++;
        if (read_data !== INIT_VALUE) begin
            n_fail++;
            $display("FAIL async_reset_w2: got %h expected %h", read_data, INIT_VALUE);
        end
        // Write attempt while held in reset
        MemWrite = 1'b1; write_data = 32'h55AA55AA;
        @(posedge clk);
        model_edge();
        #1;
        n_checks++;
        if (read_data !== INIT_VALUE) begin
            n_fail++;
            $display("FAIL reset_blocks_write: got %h expected %h", read_data, INIT_VALUE);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n = 1'b1;
        // First edge after release must accept a write
        MemWrite = 1'b1; addr = 32'd12; write_data = 32'h0F0F1234;
        @(posedge clk);
        model_edge();
        #1;
        n_checks++;
        if (read_data !== 32'h0F0F1234) begin
            n_fail++;
            $display("FAIL first_write_after_reset: got %h expected %h", read_data, 32'h0F0F1234);
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) addr = $urandom();
            else addr = 32'($urandom_range(0, 8 * DEPTH - 1));
            write_data = $urandom();
            MemWrite   = 1'($urandom_range(0, 1));
            MemRead    = ($urandom_range(0, 3) != 0);
            #1;
            exp = model_read(addr, MemRead);
            n_checks++;
            if (read_data !== exp) begin
                n_fail++;
                $display("FAIL rand_pre it=%0d addr=%h: got %h expected %h", n, addr, read_data, exp);
            end
            @(posedge clk);
            model_edge();
            #1;
            exp = model_read(addr, MemRead);
            n_checks++;
            if (read_data !== exp) begin
                n_fail++;
                $display("FAIL rand_post it=%0d addr=%h: got %h expected %h", n, addr, read_data, exp);
            end
        end
        // Sweep every word so a stray write anywhere is caught
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            addr = 32'(i * 4);
            #1;
            n_checks++;
            if (read_data !== model[i]) begin
                n_fail++;
                $display("FAIL sweep word=%0d: got %h expected %h", i, read_data, model[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_second_word();
        test_read_gating();
        test_out_of_range();
        test_same_word();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter `DEPTH_WORDS`, default 256, giving the number of 32-bit storage words; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter `INIT_VALUE`, default 32'h0000_0000, giving the value loaded into every word on reset.

Ports (name, direction, width, meaning):
REQ-003 `clk`, input, 1 bit: single clock; all writes are sampled on its rising edge.
REQ-004 `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-005 `MemWrite`, input, 1 bit: write enable.
REQ-006 `MemRead`, input, 1 bit: read enable.
REQ-007 `addr`, input, 32 bits: byte address.
REQ-008 `write_data`, input, 32 bits: word to store.
REQ-009 `read_data`, output, 32 bits: word read out.

Function
REQ-010 Storage SHALL be `DEPTH_WORDS` words of 32 bits, word-addressed.
REQ-011 Word index SHALL be `addr[31:2]`; `addr[1:0]` SHALL be ignored, so misaligned addresses round down to the word.
- Example: byte address 4 is word 1; byte address 8 is word 2.
REQ-012 An address SHALL be in range when word index < `DEPTH_WORDS`.
REQ-013 Write: on a rising `clk` edge with `rst_n`=1, `MemWrite`=1 and addr in range, the word at the index SHALL take `write_data`.
REQ-014 Write to an out-of-range addr SHALL be ignored; no word changes, no aliasing.
REQ-015 With `MemWrite`=0 at the edge, storage SHALL be unchanged.
REQ-016 Read SHALL be combinational, zero-cycle latency.
- `MemRead`=1 and addr in range: `read_data` = stored word at the index.
- Otherwise: `read_data` = 32'h0.
- `read_data` SHALL follow changes of `addr`, `MemRead` and storage within the same time step, with no clock needed.
REQ-017 Simultaneous read and write to the same word:
- Before the edge, `read_data` SHALL show the old word.
- After the edge, it SHALL show `write_data`.
- There SHALL be no internal write-to-read bypass before the edge.
REQ-018 `MemRead` and `MemWrite` SHALL be independent; both high is legal and follows REQ-013 and REQ-016.
REQ-019 No X SHALL propagate to `read_data` when `MemRead`=0.

Reset
REQ-020 While `rst_n`=0, every word SHALL be forced to `INIT_VALUE` asynchronously, without waiting for a clock edge.
REQ-021 While `rst_n`=0, writes SHALL be blocked.
REQ-022 During reset, `read_data` SHALL be `INIT_VALUE` when `MemRead`=1 with addr in range, and 0 otherwise.
REQ-023 Reset asserted mid-write (same time step as the edge) SHALL win; the word stays `INIT_VALUE`.
REQ-024 After `rst_n` rises, the first rising `clk` edge SHALL accept writes normally.

Verification
REQ-025 Write then read:
- Stimulus: after reset, addr=4, write_data=0x1234ABCD, `MemWrite`=1 for one edge; then `MemWrite`=0, `MemRead`=1.
- Required: `read_data`=0x1234ABCD within 1 ns, no clock.
REQ-026 Second word, no overwrite:
- Stimulus: write 0xBEEFBEEF to addr 8; read addr 8; read addr 4.
- Required: 0xBEEFBEEF, then 0x1234ABCD.
REQ-027 Read gating and misalignment:
- Stimulus: `MemRead`=0 at addr 4; then addr 5/6/7 with `MemRead`=1.
- Required: `read_data`=0 while `MemRead`=0; 0x1234ABCD for addr 5/6/7.
REQ-028 Out of range:
- Stimulus: write 0xFFFFFFFF to addr 4*`DEPTH_WORDS`; read that addr; read addr 0.
- Required: `read_data`=0 for the out-of-range read; word 0 unchanged (0).
REQ-029 Async reset:
- Stimulus: pull `rst_n` low between clock edges after the writes above.
- Required: addr 4 and addr 8 read 0 immediately; a write with `rst_n`=0 has no effect.
REQ-030 Same-word read/write:
- Stimulus: `MemRead`=1, addr 8, `MemWrite`=1, write_data=0xCAFEF00D.
- Required: `read_data` old value before the edge, 0xCAFEF00D after.
